// File: rtl/bus_pkg.sv
// Shared definitions for the data-bus controller slice.
//   - Default bus geometry used as parameter defaults.
//   - Device index constants for the standard device map.
//   - FSM state type for the controller.
package bus_pkg;

  localparam int unsigned BUS_DATA_W   = 16;
  localparam int unsigned BUS_ADDR_W   = 16;
  localparam int unsigned BUS_DEV_BITS = 4;

  localparam int unsigned DEV_MEM = 0;
  localparam int unsigned DEV_FP  = 1;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    ERR
  } bus_state_t;

endpackage

// File: rtl/bus_addr_decode.sv
// Combinational address decoder for the data bus.
//   DataAddr : CPU address
//   dev      : device index (upper DEV_BITS of DataAddr)
//   mapped   : dev selects an attached device (dev < NUM_DEV)
//   dev_sel  : one-hot select, all-zero when unmapped
//   dev_addr : device-local address (lower address bits)
import bus_pkg::*;

module bus_addr_decode #(
  parameter int unsigned ADDR_W   = BUS_ADDR_W,
  parameter int unsigned DEV_BITS = BUS_DEV_BITS,
  parameter int unsigned NUM_DEV  = 2
) (
  input  logic [ADDR_W-1:0]          DataAddr,
  output logic [DEV_BITS-1:0]        dev,
  output logic                       mapped,
  output logic [NUM_DEV-1:0]         dev_sel,
  output logic [ADDR_W-DEV_BITS-1:0] dev_addr
);

  always_comb begin
    dev      = DataAddr[ADDR_W-1 -: DEV_BITS];
    dev_addr = DataAddr[ADDR_W-DEV_BITS-1:0];
    mapped   = (32'(dev) < NUM_DEV);
    dev_sel  = '0;
    for (int unsigned i = 0; i < NUM_DEV; i++) begin
      dev_sel[i] = mapped && (32'(dev) == i);
    end
  end

endmodule

// File: rtl/data_bus_ctrl.sv
// Data-bus controller between the pipeline data-memory port and NUM_DEV
// memory-mapped devices.
//   Clock/Resetn           : clock, async active-low reset
//   ReadData/WriteData     : CPU request strobes (write wins if both high)
//   BusIn/DataAddr         : CPU write data and address
//   BusOut                 : read data to CPU
//   Waitreq                : CPU holds its request while high
//   BusErr                 : one-cycle pulse on an erroring completion
//   ErrValid/ErrAddr/ErrClr: sticky first-error capture and its clear
//   DevSel/DevRead/DevWrite: one-hot select and strobes to devices
//   DevAddr/DevWData       : device-local address and write data
//   DevRData/DevWait       : flattened device read data and wait requests
import bus_pkg::*;

module data_bus_ctrl #(
  parameter int unsigned DATA_W   = BUS_DATA_W,
  parameter int unsigned ADDR_W   = BUS_ADDR_W,
  parameter int unsigned DEV_BITS = BUS_DEV_BITS,
  parameter int unsigned NUM_DEV  = 2,
  parameter int unsigned TIMEOUT  = 15
) (
  input  logic                       Clock,
  input  logic                       Resetn,
  input  logic                       ReadData,
  input  logic                       WriteData,
  input  logic [DATA_W-1:0]          BusIn,
  input  logic [ADDR_W-1:0]          DataAddr,
  output logic [DATA_W-1:0]          BusOut,
  output logic                       Waitreq,
  output logic                       BusErr,
  output logic                       ErrValid,
  output logic [ADDR_W-1:0]          ErrAddr,
  input  logic                       ErrClr,
  output logic [NUM_DEV-1:0]         DevSel,
  output logic                       DevRead,
  output logic                       DevWrite,
  output logic [ADDR_W-DEV_BITS-1:0] DevAddr,
  output logic [DATA_W-1:0]          DevWData,
  input  logic [NUM_DEV*DATA_W-1:0]  DevRData,
  input  logic [NUM_DEV-1:0]         DevWait
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);

  bus_state_t          state_q, state_d;
  logic [CNT_W-1:0]    wait_cnt_q, wait_cnt_d;
  logic [DATA_W-1:0]   last_rdata_q, last_rdata_d;
  logic                err_valid_q, err_valid_d;
  logic [ADDR_W-1:0]   err_addr_q, err_addr_d;

  logic [DEV_BITS-1:0] dec_dev;
  logic                dec_mapped;
  logic [NUM_DEV-1:0]  dec_sel;

  logic                req, is_rd, is_wr;
  logic                drive, complete;
  logic [DATA_W-1:0]   sel_rdata;
  logic                sel_wait;

  bus_addr_decode #(
    .ADDR_W   (ADDR_W),
    .DEV_BITS (DEV_BITS),
    .NUM_DEV  (NUM_DEV)
  ) u_decode (
    .DataAddr (DataAddr),
    .dev      (dec_dev),
    .mapped   (dec_mapped),
    .dev_sel  (dec_sel),
    .dev_addr (DevAddr)
  );

  // dec_dev is fully represented by dec_sel; it is kept for visibility only.
  logic unused_dev;
  assign unused_dev = ^dec_dev;

  // Mux the selected device's wait and read data through the one-hot select.
  always_comb begin
    sel_rdata = '0;
    sel_wait  = 1'b0;
    for (int unsigned i = 0; i < NUM_DEV; i++) begin
      if (dec_sel[i]) begin
        sel_rdata = DevRData[i*DATA_W +: DATA_W];
        sel_wait  = DevWait[i];
      end
    end
  end

  always_comb begin
    req   = ReadData | WriteData;
    is_wr = WriteData;
    is_rd = ReadData & ~WriteData;

    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    drive      = 1'b0;
    complete   = 1'b0;
    Waitreq    = 1'b0;
    BusErr     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req) begin
          if (dec_mapped) begin
            drive = 1'b1;
            if (sel_wait) begin
              Waitreq    = 1'b1;
              wait_cnt_d = CNT_W'(1);
              state_d    = ACCESS;
            end else begin
              complete = 1'b1;
            end
          end else begin
            BusErr = 1'b1;
          end
        end
      end
      ACCESS: begin
        if (!req || !dec_mapped) begin
          state_d    = IDLE;
          wait_cnt_d = '0;
        end else begin
          drive = 1'b1;
          if (!sel_wait) begin
            complete   = 1'b1;
            state_d    = IDLE;
            wait_cnt_d = '0;
          end else if (wait_cnt_q == CNT_LIMIT) begin
            Waitreq = 1'b1;
            state_d = ERR;
          end else begin
            Waitreq    = 1'b1;
            wait_cnt_d = wait_cnt_q + 1'b1;
          end
        end
      end
      ERR: begin
        BusErr     = 1'b1;
        state_d    = IDLE;
        wait_cnt_d = '0;
      end
      default: begin
        state_d    = IDLE;
        wait_cnt_d = '0;
      end
    endcase

    // Strobes and handshake outputs are forced low for the whole reset
    // assertion, not just from the next edge.
    if (!Resetn) begin
      drive    = 1'b0;
      complete = 1'b0;
      Waitreq  = 1'b0;
      BusErr   = 1'b0;
    end
  end

  always_comb begin
    DevSel   = drive ? dec_sel : '0;
    DevRead  = drive & is_rd;
    DevWrite = drive & is_wr;
    DevWData = BusIn;

    if (complete && is_rd) begin
      BusOut = sel_rdata;
    end else if (BusErr) begin
      BusOut = '0;
    end else begin
      BusOut = last_rdata_q;
    end

    last_rdata_d = (complete && is_rd) ? sel_rdata : last_rdata_q;

    err_valid_d = err_valid_q;
    err_addr_d  = err_addr_q;
    if (ErrClr) begin
      err_valid_d = 1'b0;
      err_addr_d  = '0;
    end else if (BusErr && !err_valid_q) begin
      err_valid_d = 1'b1;
      err_addr_d  = DataAddr;
    end

    ErrValid = err_valid_q;
    ErrAddr  = err_addr_q;
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q      <= IDLE;
      wait_cnt_q   <= '0;
      last_rdata_q <= '0;
      err_valid_q  <= 1'b0;
      err_addr_q   <= '0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      last_rdata_q <= last_rdata_d;
      err_valid_q  <= err_valid_d;
      err_addr_q   <= err_addr_d;
    end
  end

endmodule

// File: tb/tb_data_bus_ctrl.sv
// Scoreboard bench for data_bus_ctrl: a driver issues transactions and
// pushes the expected outcome; a negedge monitor checks every request and
// idle cycle and pops on each completion (Waitreq low with a request).
import bus_pkg::*;

module tb_data_bus_ctrl;

  localparam int unsigned TIMEOUT = 15;
  localparam int unsigned NUM_DEV = 2;

  logic        Clock = 1'b0;
  logic        Resetn;
  logic        ReadData, WriteData;
  logic [15:0] BusIn, DataAddr;
  logic [15:0] BusOut;
  logic        Waitreq, BusErr, ErrValid;
  logic [15:0] ErrAddr;
  logic        ErrClr;
  logic [1:0]  DevSel;
  logic        DevRead, DevWrite;
  logic [11:0] DevAddr;
  logic [15:0] DevWData;
  logic [31:0] DevRData;
  logic [1:0]  DevWait;

  data_bus_ctrl #(
    .DATA_W   (16),
    .ADDR_W   (16),
    .DEV_BITS (4),
    .NUM_DEV  (NUM_DEV),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .Clock     (Clock),
    .Resetn    (Resetn),
    .ReadData  (ReadData),
    .WriteData (WriteData),
    .BusIn     (BusIn),
    .DataAddr  (DataAddr),
    .BusOut    (BusOut),
    .Waitreq   (Waitreq),
    .BusErr    (BusErr),
    .ErrValid  (ErrValid),
    .ErrAddr   (ErrAddr),
    .ErrClr    (ErrClr),
    .DevSel    (DevSel),
    .DevRead   (DevRead),
    .DevWrite  (DevWrite),
    .DevAddr   (DevAddr),
    .DevWData  (DevWData),
    .DevRData  (DevRData),
    .DevWait   (DevWait)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic [15:0] addr;
    bit          rd;
    bit          wr;
    logic [15:0] wdata;
    bit          mapped;
    int unsigned dev;
    int unsigned waits;
    bit          err;
    logic [15:0] dev_rdata;
  } exp_t;

  exp_t        sb[$];
  int unsigned errs   = 0;
  int unsigned checks = 0;
  bit          mon_en = 1'b0;
  int unsigned mon_n  = 0;
  logic [15:0] m_last  = '0;
  bit          m_valid = 1'b0;
  logic [15:0] m_addr  = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor / scoreboard consumer.
  always @(negedge Clock) begin : monitor
    exp_t        e;
    bit          err_now, err_cyc, drv;
    logic [1:0]  exp_sel;
    logic [15:0] exp_out;
    err_now = 1'b0;
    if (mon_en && Resetn) begin
      chk("err_valid", ErrValid, m_valid);
      chk("err_addr", ErrAddr, m_addr);
      if (ReadData || WriteData) begin
        if (sb.size() == 0) begin
          checks++;
          errs++;
          $display("FAIL unexpected_req: request with empty scoreboard at %0t", $time);
        end else begin
          e       = sb[0];
          err_cyc = e.mapped && e.err && (mon_n == TIMEOUT + 1);
          drv     = e.mapped && !err_cyc;
          exp_sel = drv ? 2'(1 << e.dev) : 2'b00;
          chk("dev_sel", DevSel, exp_sel);
          chk("dev_read", DevRead, drv && e.rd);
          chk("dev_write", DevWrite, drv && e.wr);
          if (drv) begin
            chk("dev_addr", DevAddr, e.addr[11:0]);
            chk("dev_wdata", DevWData, e.wdata);
          end
          if (Waitreq) begin
            mon_n++;
          end else begin
            chk("wait_cycles", mon_n, e.waits);
            chk("bus_err", BusErr, e.err);
            exp_out = e.err ? 16'h0 : (e.rd ? e.dev_rdata : m_last);
            chk("bus_out", BusOut, exp_out);
            if (e.rd && !e.err) m_last = e.dev_rdata;
            err_now = e.err;
            void'(sb.pop_front());
            mon_n = 0;
          end
        end
      end else begin
        chk("idle_waitreq", Waitreq, 1'b0);
        chk("idle_bus_err", BusErr, 1'b0);
        chk("idle_bus_out", BusOut, m_last);
        chk("idle_strobes", {DevSel, DevRead, DevWrite}, 4'b0);
      end
      if (ErrClr) begin
        m_valid = 1'b0;
        m_addr  = '0;
      end else if (err_now && !m_valid) begin
        m_valid = 1'b1;
        m_addr  = e.addr;
      end
    end
  end

  task automatic finish_run();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  endtask

  task automatic idle(input bit clr);
    ReadData  = 1'b0;
    WriteData = 1'b0;
    DevWait   = '0;
    ErrClr    = clr;
    @(posedge Clock);
    #1;
    ErrClr = 1'b0;
  endtask

  // Device holds its wait request for the first w strobe cycles.
  task automatic do_txn(input logic [15:0] addr, input bit rd, input bit wr,
                        input logic [15:0] wdata, input int unsigned w,
                        input logic [31:0] rdata);
    exp_t        e;
    bit          done;
    int unsigned k;
    logic [1:0]  dsel;
    e.addr   = addr;
    e.rd     = rd && !wr;
    e.wr     = wr;
    e.wdata  = wdata;
    e.dev    = int'(addr[15:12]);
    e.mapped = (e.dev < NUM_DEV);
    e.dev_rdata = 16'h0;
    dsel = 2'b00;
    if (e.mapped) begin
      e.dev_rdata = (e.dev == 0) ? rdata[15:0] : rdata[31:16];
      dsel = 2'(1 << e.dev);
    end
    if (!e.mapped) begin
      e.waits = 0;
      e.err   = 1'b1;
    end else if (w > TIMEOUT) begin
      e.waits = TIMEOUT + 1;
      e.err   = 1'b1;
    end else begin
      e.waits = w;
      e.err   = 1'b0;
    end
    sb.push_back(e);

    ReadData  = rd;
    WriteData = wr;
    DataAddr  = addr;
    BusIn     = wdata;
    DevRData  = rdata;
    DevWait   = (2'($urandom) & ~dsel) | ((w > 0) ? dsel : 2'b00);
    done = 1'b0;
    k    = 0;
    for (int c = 0; c < 64 && !done; c++) begin
      @(negedge Clock);
      done = !Waitreq;
      @(posedge Clock);
      #1;
      if (!done) begin
        k++;
        DevWait = (DevWait & ~dsel) | ((k < w) ? dsel : 2'b00);
      end
    end
    ReadData  = 1'b0;
    WriteData = 1'b0;
    DevWait   = '0;
    if (!done) begin
      checks++;
      errs++;
      $display("FAIL txn_bound: Waitreq never dropped for addr %0h", addr);
      finish_run();
    end
  endtask

  initial begin : driver
    logic [15:0] a;
    int unsigned mode, r, w;
    Resetn    = 1'b0;
    ReadData  = 1'b0;
    WriteData = 1'b0;
    BusIn     = '0;
    DataAddr  = '0;
    ErrClr    = 1'b0;
    DevRData  = '0;
    DevWait   = '0;

    // Request during reset must not leak strobes or handshake.
    #2;
    ReadData = 1'b1;
    DevWait  = 2'b01;
    #1;
    chk("rst_dev_read", DevRead, 1'b0);
    chk("rst_dev_sel", DevSel, 2'b00);
    chk("rst_waitreq", Waitreq, 1'b0);
    chk("rst_bus_out", BusOut, 16'h0);
    chk("rst_err_valid", {ErrValid, ErrAddr}, 17'h0);
    ReadData = 1'b0;
    DevWait  = '0;
    repeat (3) @(posedge Clock);
    #1;
    Resetn = 1'b1;
    mon_en = 1'b1;
    idle(1'b0);

    // Zero-wait read from DEV_MEM.
    do_txn({4'(DEV_MEM), 12'h123}, 1'b1, 1'b0, 16'h0, 0, {16'h1111, 16'hBEEF});
    idle(1'b0);
    idle(1'b0);
    // Multi-cycle write to DEV_FP.
    do_txn({4'(DEV_FP), 12'h004}, 1'b0, 1'b1, 16'h5A5A, 3, 32'hCAFE_F00D);
    idle(1'b0);
    // Timeout on a stuck device.
    do_txn({4'(DEV_FP), 12'h000}, 1'b1, 1'b0, 16'h0, 40, 32'h1234_5678);
    idle(1'b0);
    idle(1'b1);
    // Unmapped accesses; the second must not overwrite the first.
    do_txn(16'h7000, 1'b1, 1'b0, 16'h0, 0, 32'hFFFF_FFFF);
    idle(1'b0);
    do_txn(16'h9000, 1'b1, 1'b0, 16'h0, 0, 32'hFFFF_FFFF);
    idle(1'b0);
    idle(1'b1);
    // Read and write together: write wins.
    do_txn(16'h0010, 1'b1, 1'b1, 16'h3C3C, 0, 32'h7777_6666);
    idle(1'b0);
    // Boundary: longest wait that still completes.
    do_txn({4'(DEV_FP), 12'hABC}, 1'b1, 1'b0, 16'h0, TIMEOUT, 32'hA5A5_0F0F);
    idle(1'b0);

    for (int n = 0; n < 60; n++) begin
      a    = 16'($urandom);
      a[15:12] = 4'($urandom_range(0, 3));
      mode = $urandom_range(0, 2);
      r    = $urandom_range(0, 9);
      if (r < 4)      w = 0;
      else if (r < 8) w = $urandom_range(1, 5);
      else            w = $urandom_range(13, 18);
      do_txn(a, mode != 1, mode != 0, 16'($urandom), w, $urandom);
      idle($urandom_range(0, 3) == 0);
    end

    // Reset during the second wait cycle of an access.
    mon_en   = 1'b0;
    ReadData = 1'b1;
    DataAddr = {4'(DEV_FP), 12'h000};
    DevWait  = 2'b10;
    @(posedge Clock);
    #1;
    chk("pre_rst_dev_read", DevRead, 1'b1);
    #2;
    Resetn = 1'b0;
    #1;
    chk("rst_mid_dev_read", DevRead, 1'b0);
    chk("rst_mid_dev_sel", DevSel, 2'b00);
    chk("rst_mid_waitreq", Waitreq, 1'b0);
    chk("rst_mid_bus_err", BusErr, 1'b0);
    ReadData = 1'b0;
    DevWait  = '0;
    for (int i = 0; i < 2; i++) begin
      @(negedge Clock);
      chk("rst_hold_bus_err", BusErr, 1'b0);
    end
    @(posedge Clock);
    #1;
    Resetn  = 1'b1;
    sb.delete();
    mon_n   = 0;
    m_last  = '0;
    m_valid = 1'b0;
    m_addr  = '0;
    mon_en  = 1'b1;
    idle(1'b0);
    do_txn({4'(DEV_MEM), 12'h040}, 1'b1, 1'b0, 16'h0, 0, {16'h0, 16'h1234});
    idle(1'b0);
    idle(1'b0);

    if (sb.size() != 0) begin
      checks++;
      errs++;
      $display("FAIL scoreboard_drain: %0d entries left", sb.size());
    end
    finish_run();
  end

endmodule
